// File: rtl/gates_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gates_checker_pkg
//  Description : Shared definitions for the basic-gates checker family:
//                gate bit indices within the 6-bit response word, gate count
//                and the checker FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package gates_checker_pkg;

    // Bit positions of each gate output inside z / ref_out
    localparam int GATE_AND  = 0;
    localparam int GATE_NAND = 1;
    localparam int GATE_OR   = 2;
    localparam int GATE_NOR  = 3;
    localparam int GATE_XOR  = 4;
    localparam int GATE_XNOR = 5;
    localparam int NUM_GATES = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : gates_checker_pkg
`default_nettype wire

// File: rtl/gates_ref_model.sv
`default_nettype none
// ============================================================================
//  Module      : gates_ref_model
//  Description : Combinational golden model of the 6-output basic-gates
//                block. Shared by the lab checkers.
//  Ports       : a, b     - gate stimulus
//                ref_out  - expected response, bit order AND, NAND, OR,
//                           NOR, XOR, XNOR (bit 0 .. bit 5)
//  Revision    : 1.0 - initial release
// ============================================================================
module gates_ref_model
    import gates_checker_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] ref_out
);

    always_comb begin
        ref_out            = '0;
        ref_out[GATE_AND]  =   a & b;
        ref_out[GATE_NAND] = ~(a & b);
        ref_out[GATE_OR]   =   a | b;
        ref_out[GATE_NOR]  = ~(a | b);
        ref_out[GATE_XOR]  =   a ^ b;
        ref_out[GATE_XNOR] = ~(a ^ b);
    end

endmodule : gates_ref_model
`default_nettype wire

// File: rtl/gates_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gates_checker
//  Description : Self-checking consumer for the basic-gates block. Captures
//                NUM_VECTORS valid samples of {a, b, z} per run, compares z
//                against the golden model and reports a saturating error
//                count, a sticky per-gate error mask and the index of the
//                first failing vector.
//  Ports       : clk, rst (sync, active-high)
//                start          - pulse, begins a run from IDLE/DONE
//                valid, a, b, z - sample strobe, stimulus and gate response
//                busy, done, pass, err_count, err_mask, first_err_idx
//  Revision    : 1.0 - initial release
// ============================================================================
module gates_checker
    import gates_checker_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int VEC_WIDTH   = 8,
    parameter int ERR_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 valid,
    input  logic                 a,
    input  logic                 b,
    input  logic [NUM_GATES-1:0] z,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [NUM_GATES-1:0] err_mask,
    output logic [VEC_WIDTH-1:0] first_err_idx
);

    localparam logic [VEC_WIDTH-1:0] c_num_vec = VEC_WIDTH'(NUM_VECTORS);
    localparam logic [VEC_WIDTH-1:0] c_last    = c_num_vec - 1'b1;

    state_t                 r_state;
    state_t                 w_next;

    logic [VEC_WIDTH-1:0]   r_vec_cnt;

    // S1: captured sample awaiting comparison
    logic                   r_s1_vld;
    logic                   r_s1_a;
    logic                   r_s1_b;
    logic [NUM_GATES-1:0]   r_s1_z;
    logic [VEC_WIDTH-1:0]   r_s1_idx;

    // Result registers (S2 writes these)
    logic [ERR_WIDTH-1:0]   r_err_count;
    logic [NUM_GATES-1:0]   r_err_mask;
    logic [VEC_WIDTH-1:0]   r_first_err;

    logic [NUM_GATES-1:0]   w_ref;
    logic [NUM_GATES-1:0]   w_diff;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_retire_last;

    gates_ref_model u_ref (
        .a       (r_s1_a),
        .b       (r_s1_b),
        .ref_out (w_ref)
    );

    assign w_diff        = r_s1_z ^ w_ref;
    assign w_accept      = valid && (r_state == RUN) && (r_vec_cnt < c_num_vec);
    assign w_start       = start && (r_state != RUN);
    assign w_retire_last = r_s1_vld && (r_s1_idx == c_last);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_retire_last) w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_next = RUN;
            end
            default: w_next = IDLE;
        endcase
        pass = done && (r_err_count == '0);
    end

    // ------------------------------------------------------------------
    // Sample pipeline and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_cnt   <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_a      <= 1'b0;
            r_s1_b      <= 1'b0;
            r_s1_z      <= '0;
            r_s1_idx    <= '0;
            r_err_count <= '0;
            r_err_mask  <= '0;
            r_first_err <= '1;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_a    <= a;
                r_s1_b    <= b;
                r_s1_z    <= z;
                r_s1_idx  <= r_vec_cnt;
                r_vec_cnt <= r_vec_cnt + 1'b1;
            end

            // A start can only happen outside RUN, so no compare is in
            // flight and clearing the results cannot drop a retiring sample.
            if (w_start) begin
                r_vec_cnt   <= '0;
                r_err_count <= '0;
                r_err_mask  <= '0;
                r_first_err <= '1;
            end else if (r_s1_vld && (|w_diff)) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                r_err_mask <= r_err_mask | w_diff;
                // All-ones marks "no error yet"; indices never reach it
                if (r_first_err == '1) begin
                    r_first_err <= r_s1_idx;
                end
            end
        end
    end

    assign err_count     = r_err_count;
    assign err_mask      = r_err_mask;
    assign first_err_idx = r_first_err;

endmodule : gates_checker
`default_nettype wire

// File: tb/tb_gates_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gates_checker
//  Description : Self-checking bench for gates_checker. A behavioural model
//                (truth table + pending-compare queue) predicts every output
//                each cycle; directed scenarios add literal expectations.
//                A second instance (255 vectors, 4-bit error count) covers
//                error-count saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gates_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, valid, a, b;
    logic [5:0] z;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [5:0] err_mask;
    logic [7:0] first_err_idx;

    logic       start2, valid2, a2, b2;
    logic [5:0] z2;
    logic       busy2, done2, pass2;
    logic [3:0] err_count2;
    logic [5:0] err_mask2;
    logic [7:0] first2;

    gates_checker #(.NUM_VECTORS(4), .VEC_WIDTH(8), .ERR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .z(z),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .err_mask(err_mask), .first_err_idx(first_err_idx)
    );

    gates_checker #(.NUM_VECTORS(255), .VEC_WIDTH(8), .ERR_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .valid(valid2), .a(a2), .b(b2), .z(z2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .err_mask(err_mask2), .first_err_idx(first2)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Expected gate response indexed by {a,b}; bits 5..0 = XNOR XOR NOR OR NAND AND
    logic [5:0] ref_tbl [0:3] = '{6'b101010, 6'b010110, 6'b010110, 6'b100101};

    // Vector order for a run: (a,b) = 00, 10, 01, 11
    logic vec_a [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic vec_b [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};

    // A correct gates block, written independently of the table
    function automatic logic [5:0] gates_blk(input logic ia, input logic ib);
        return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ia | ib, ~(ia & ib), ia & ib};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model of the 4-vector instance
    // ------------------------------------------------------------------
    typedef struct {
        logic [5:0] diff;
        bit         bad;
        int         idx;
    } pend_t;

    pend_t      pq[$];
    bit         m_run = 1'b0;
    bit         m_done = 1'b0;
    int         m_acc = 0;
    int         m_err = 0;
    logic [5:0] m_mask = '0;
    int         m_first = 255;
    bit         m_was_run;

    always @(posedge clk) begin
        if (rst) begin
            pq.delete();
            m_run = 1'b0; m_done = 1'b0; m_acc = 0;
            m_err = 0; m_mask = '0; m_first = 255;
        end else begin
            m_was_run = m_run;
            // Samples accepted on the previous edge are judged on this one
            while (pq.size() > 0) begin
                pend_t p;
                p = pq.pop_front();
                if (p.bad) begin
                    if (m_err < 255) m_err++;
                    m_mask |= p.diff;
                    if (m_first == 255) m_first = p.idx;
                end
                if (p.idx == 3) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (m_was_run && valid && m_acc < 4) begin
                pend_t n;
                n.diff = z ^ ref_tbl[{a, b}];
                n.bad  = (z !== ref_tbl[{a, b}]);
                n.idx  = m_acc;
                pq.push_back(n);
                m_acc++;
            end
            if (start && !m_was_run) begin
                m_run = 1'b1; m_done = 1'b0; m_acc = 0;
                m_err = 0; m_mask = '0; m_first = 255;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (busy !== m_run || done !== m_done || pass !== (m_done && m_err == 0) ||
                err_count !== 8'(m_err) || err_mask !== m_mask || first_err_idx !== 8'(m_first)) begin
                bad++;
                $display("FAIL model_cmp t=%0t got busy=%b done=%b pass=%b err=%0d mask=%b first=%0d want busy=%b done=%b pass=%b err=%0d mask=%b first=%0d",
                         $time, busy, done, pass, err_count, err_mask, first_err_idx,
                         m_run, m_done, (m_done && m_err == 0), m_err, m_mask, m_first);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers (all drive on the falling edge)
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_pass"},  32'(pass), 32'd0);
        check({tag, "_err"},   32'(err_count), 32'd0);
        check({tag, "_mask"},  32'(err_mask), 32'd0);
        check({tag, "_first"}, 32'(first_err_idx), 32'hFF);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic ia, input logic ib, input logic [5:0] corrupt);
        valid = 1'b1; a = ia; b = ib;
        z = gates_blk(ia, ib) ^ corrupt;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Full 4-vector run; vector corr_idx gets corr_mask XORed into z
    task automatic run4(input int corr_idx, input logic [5:0] corr_mask, input string tag);
        pulse_start();
        for (int i = 0; i < 4; i++)
            send(vec_a[i], vec_b[i], (i == corr_idx) ? corr_mask : 6'h00);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; a = 1'b0; b = 1'b0; z = '0;
        start2 = 1'b0; valid2 = 1'b0; a2 = 1'b0; b2 = 1'b0; z2 = '0;

        // 1: reset
        @(negedge clk);
        chk_on = 1'b1;
        do_reset(2);
        check_reset_vals("t1");

        // 2: clean run
        run4(-1, 6'h00, "t2");
        check("t2_pass",  32'(pass), 32'd1);
        check("t2_err",   32'(err_count), 32'd0);
        check("t2_mask",  32'(err_mask), 32'h00);
        check("t2_first", 32'(first_err_idx), 32'hFF);

        // 3: XOR output stuck low on vector 2 (a=0,b=1)
        run4(2, 6'b010000, "t3");
        check("t3_err",   32'(err_count), 32'd1);
        check("t3_mask",  32'(err_mask), 32'b010000);
        check("t3_first", 32'(first_err_idx), 32'd2);
        check("t3_pass",  32'(pass), 32'd0);

        // 5: reset in the middle of a run, with a corrupted sample in flight
        pulse_start();
        send(vec_a[0], vec_b[0], 6'h00);
        send(vec_a[1], vec_b[1], 6'h3F);
        do_reset(1);
        check_reset_vals("t5_rst");
        repeat (3) @(negedge clk);
        check("t5_idle_err", 32'(err_count), 32'd0);
        run4(-1, 6'h00, "t5");
        check("t5_pass", 32'(pass), 32'd1);

        // 6: spurious start and out-of-run valids
        do_reset(1);
        send(1'b1, 1'b1, 6'h3F);
        @(negedge clk);
        check("t6_idle_valid_err", 32'(err_count), 32'd0);
        check("t6_idle_busy",      32'(busy), 32'd0);
        pulse_start();
        send(vec_a[0], vec_b[0], 6'h00);
        send(vec_a[1], vec_b[1], 6'h00);
        pulse_start();
        check("t6_still_busy", 32'(busy), 32'd1);
        send(vec_a[2], vec_b[2], 6'h00);
        send(vec_a[3], vec_b[3], 6'h00);
        @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        send(1'b0, 1'b0, 6'h3F);
        repeat (2) @(negedge clk);
        check("t6_pass",  32'(pass), 32'd1);
        check("t6_err",   32'(err_count), 32'd0);
        check("t6_mask",  32'(err_mask), 32'h00);
        check("t6_first", 32'(first_err_idx), 32'hFF);

        // 4: saturation on the 255-vector / 4-bit-count instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 255; i++) begin
            logic [1:0] cnt;
            cnt = 2'(i);
            valid2 = 1'b1; a2 = cnt[1]; b2 = cnt[0];
            z2 = ~gates_blk(cnt[1], cnt[0]);
            @(negedge clk);
            if (i == 14) check("t4_err_at_15", 32'(err_count2), 32'd14);
        end
        valid2 = 1'b0;
        for (int k = 0; k < 10 && !done2; k++) @(negedge clk);
        check("t4_done",  32'(done2), 32'd1);
        check("t4_err",   32'(err_count2), 32'hF);
        check("t4_mask",  32'(err_mask2), 32'h3F);
        check("t4_first", 32'(first2), 32'd0);
        check("t4_pass",  32'(pass2), 32'd0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gates_checker
`default_nettype wire
